// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
// State encoding, item indices, coin values, one-hot decode helper.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DISPENSE,
        CHANGE,
        REFUND
    } state_t;

    localparam int CREDIT_W = 6;

    localparam logic [1:0] ITEM_1 = 2'd0;
    localparam logic [1:0] ITEM_2 = 2'd1;
    localparam logic [1:0] ITEM_3 = 2'd2;
    localparam logic [1:0] ITEM_4 = 2'd3;

    localparam logic [CREDIT_W-1:0] COIN5  = 6'd5;
    localparam logic [CREDIT_W-1:0] COIN10 = 6'd10;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } sel_t;

    // Zero or multiple bits set yields valid=0.
    function automatic sel_t onehot_to_idx(input logic [3:0] v);
        sel_t r;
        r.valid = 1'b1;
        r.idx   = ITEM_1;
        case (v)
            4'b0001: r.idx = ITEM_1;
            4'b0010: r.idx = ITEM_2;
            4'b0100: r.idx = ITEM_3;
            4'b1000: r.idx = ITEM_4;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Inactivity counter for the coin-collect phase.
// Ports: clk, rst (sync, active-high), clr, en -> expired at TIMEOUT_CYC-1.
module vend_timeout_timer #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int TMR_W       = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] cnt;

    // Saturates at LAST so a stalled count never wraps back to zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/vend_txn_controller.sv
// Single-credit vending sequencer: select, collect coins, dispense, change.
// Ports: coin/select/cancel inputs, product and change valid/ready pairs,
// credit, coin_reject/sel_error pulses, busy. All outputs registered.
module vend_txn_controller
    import vend_pkg::*;
#(
    parameter int PRICE_1     = 15,
    parameter int PRICE_2     = 20,
    parameter int PRICE_3     = 25,
    parameter int PRICE_4     = 30,
    parameter int TIMEOUT_CYC = 1000,
    parameter int TMR_W       = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          item_no,
    input  logic                sel_valid,
    input  logic                five_rup,
    input  logic                ten_rup,
    input  logic                cancel,
    output logic                product,
    output logic [1:0]          product_id,
    input  logic                dispense_ready,
    output logic                change,
    output logic [CREDIT_W-1:0] change_amt,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_error,
    output logic                busy
);

    state_t state, state_n;

    logic [1:0]          item_idx, item_idx_n;
    logic [CREDIT_W-1:0] credit_n, change_amt_n;
    logic [CREDIT_W-1:0] price, coin_val, credit_upd;
    logic                any_coin, coin_ok, coin_both;
    logic                coin_reject_n, sel_error_n;
    logic                tmr_clr, tmr_en, tmr_expired;
    sel_t                sel;

    vend_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TMR_W      (TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expired(tmr_expired)
    );

    assign tmr_en    = (state == COLLECT);
    assign any_coin  = five_rup | ten_rup;
    assign coin_both = five_rup & ten_rup;
    assign coin_ok   = five_rup ^ ten_rup;
    assign coin_val  = ten_rup ? COIN10 : COIN5;
    assign credit_upd = credit + (coin_ok ? coin_val : '0);
    assign sel       = onehot_to_idx(item_no);

    always_comb begin
        price = '0;
        unique case (item_idx)
            ITEM_1: price = CREDIT_W'(PRICE_1);
            ITEM_2: price = CREDIT_W'(PRICE_2);
            ITEM_3: price = CREDIT_W'(PRICE_3);
            ITEM_4: price = CREDIT_W'(PRICE_4);
        endcase
    end

    always_comb begin
        state_n       = state;
        credit_n      = credit;
        item_idx_n    = item_idx;
        change_amt_n  = change_amt;
        coin_reject_n = 1'b0;
        sel_error_n   = 1'b0;
        tmr_clr       = 1'b0;
        unique case (state)
            IDLE: begin
                coin_reject_n = any_coin;
                if (sel_valid) begin
                    if (sel.valid) begin
                        item_idx_n = sel.idx;
                        state_n    = COLLECT;
                        tmr_clr    = 1'b1;
                    end else begin
                        sel_error_n = 1'b1;
                    end
                end
            end
            COLLECT: begin
                // Coin is credited before cancel/timeout is evaluated,
                // so a paying coin beats a simultaneous cancel.
                coin_reject_n = coin_both;
                credit_n      = credit_upd;
                tmr_clr       = coin_ok;
                if (credit_upd >= price) begin
                    state_n = DISPENSE;
                end else if (cancel || (tmr_expired && !coin_ok)) begin
                    if (credit_upd != '0) begin
                        state_n      = REFUND;
                        change_amt_n = credit_upd;
                        credit_n     = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DISPENSE: begin
                coin_reject_n = any_coin;
                if (dispense_ready) begin
                    credit_n = '0;
                    if (credit > price) begin
                        change_amt_n = credit - price;
                        state_n      = CHANGE;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            CHANGE, REFUND: begin
                coin_reject_n = any_coin;
                if (change_ready) begin
                    change_amt_n = '0;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= '0;
            item_idx    <= ITEM_1;
            change_amt  <= '0;
            product     <= 1'b0;
            product_id  <= 2'd0;
            change      <= 1'b0;
            coin_reject <= 1'b0;
            sel_error   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            item_idx    <= item_idx_n;
            change_amt  <= change_amt_n;
            product     <= (state_n == DISPENSE);
            product_id  <= (state_n == DISPENSE) ? item_idx_n : 2'd0;
            change      <= (state_n == CHANGE) || (state_n == REFUND);
            coin_reject <= coin_reject_n;
            sel_error   <= sel_error_n;
            busy        <= (state_n != IDLE);
        end
    end

endmodule
